// File: rtl/lsu_pkg.sv
// Shared types and helpers for the byte-serial load/store initiator.
package lsu_pkg;

  // Size/sign encoding carried on req_ctrl
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } dmctrl_e;

  // Address map regions selected by addr[13:12]
  localparam logic [1:0] REG_MEM      = 2'b00;
  localparam logic [1:0] REG_LED      = 2'b01;
  localparam logic [1:0] REG_SW       = 2'b10;
  localparam logic [1:0] REG_UNMAPPED = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // Number of bus bytes for a size encoding (low two bits pick the size)
  function automatic logic [2:0] byte_cnt(input logic [2:0] ctrl);
    logic [2:0] n;
    case (ctrl[1:0])
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // True for the five encodings the pipeline may legally issue
  function automatic logic ctrl_legal(input logic [2:0] ctrl);
    logic ok;
    case (ctrl)
      LB, LH, LW, LBU, LHU: ok = 1'b1;
      default:              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of the assembled load bytes.
module lsu_load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  i_ctrl,
  input  logic [31:0] i_acc,
  output logic [31:0] o_rdata
);

  // Bytes arrive MSB first, so the loaded value is always right-justified
  always_comb begin
    o_rdata = i_acc;
    case (i_ctrl)
      LB:      o_rdata = {{24{i_acc[7]}}, i_acc[7:0]};
      LH:      o_rdata = {{16{i_acc[15]}}, i_acc[15:0]};
      LBU:     o_rdata = {24'h0, i_acc[7:0]};
      LHU:     o_rdata = {16'h0, i_acc[15:0]};
      default: o_rdata = i_acc;
    endcase
  end

endmodule

// File: rtl/lsu_byte_master.sv
// MEM-stage load/store initiator: serialises one word/half/byte request
// into big-endian byte transfers on a req/ack bus and returns the result.
module lsu_byte_master
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_ctrl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic              busy,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        bus_wdata,
  input  logic [7:0]        bus_rdata,
  input  logic              bus_ack
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

  lsu_state_e        r_state;
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [31:0]       r_wsh;       // store bytes, next one always in [31:24]
  logic [31:0]       r_acc;       // load bytes shifted in from the right
  logic [1:0]        r_cnt;       // bytes remaining after the current one
  logic [WAIT_W-1:0] r_wait;
  logic [2:0]        r_ctrl;
  logic              r_we;
  logic              r_resp_valid;
  logic              r_resp_err;

  logic [2:0]        w_n;
  logic [2:0]        w_off;
  logic              w_dec_err;
  logic [31:0]       w_walign;
  logic [31:0]       w_ext;

  // Request decode, evaluated only while idle
  always_comb begin
    w_n       = byte_cnt(req_ctrl);
    w_off     = 3'd4 - w_n;
    w_dec_err = (req_addr[1:0] != 2'b00) ||
                (req_addr[13:12] == REG_UNMAPPED) ||
                !ctrl_legal(req_ctrl) ||
                (req_we && (req_ctrl == LBU || req_ctrl == LHU));
    case (w_n)
      3'd1:    w_walign = {req_wdata[7:0], 24'h0};
      3'd2:    w_walign = {req_wdata[15:0], 16'h0};
      default: w_walign = req_wdata;
    endcase
  end

  // Main FSM: accept, stream bytes with per-byte timeout, one-cycle response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bus_req    <= 1'b0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_wsh        <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_wait       <= '0;
      r_ctrl       <= '0;
      r_we         <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_ctrl <= req_ctrl;
            r_we   <= req_we;
            r_acc  <= '0;
            r_wait <= '0;
            if (w_dec_err) begin
              // Rejected without touching the bus
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
            end else begin
              r_state    <= ST_XFER;
              r_bus_req  <= 1'b1;
              r_bus_we   <= req_we;
              r_bus_addr <= req_addr + ADDR_W'(w_off);
              r_wsh      <= w_walign;
              r_cnt      <= 2'(w_n - 3'd1);
              r_resp_err <= 1'b0;
            end
          end
        end
        ST_XFER: begin
          if (bus_ack) begin
            r_acc  <= {r_acc[23:0], bus_rdata};
            r_wait <= '0;
            if (r_cnt == 2'd0) begin
              r_bus_req    <= 1'b0;
              r_bus_we     <= 1'b0;
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
            end else begin
              // Next byte goes out immediately; bus_req never dips
              r_cnt      <= r_cnt - 2'd1;
              r_bus_addr <= r_bus_addr + ADDR_W'(1);
              r_wsh      <= {r_wsh[23:0], 8'h0};
            end
          end else if (r_wait == WAIT_LAST) begin
            // Responder gave up on us; already-written bytes stay written
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_state      <= ST_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
          end else begin
            r_wait <= r_wait + WAIT_W'(1);
          end
        end
        ST_RESP: begin
          r_state    <= ST_IDLE;
          r_resp_err <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  lsu_load_extend u_ext (
    .i_ctrl  (r_ctrl),
    .i_acc   (r_acc),
    .o_rdata (w_ext)
  );

  assign req_ready  = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_wsh[31:24];
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  // Data only for successful loads, and only in the response cycle
  assign resp_rdata = (r_resp_valid && !r_resp_err && !r_we) ? w_ext : 32'h0;

endmodule

// File: tb/tb_lsu_byte_master.sv
// Directed bench for lsu_byte_master with a byte memory responder.
module tb_lsu_byte_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_ctrl = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;

  int n_vec = 0;
  int n_bad = 0;

  // Responder state
  logic [7:0] mem [256];
  int         wcnt;
  int         ack_wait = 0;
  bit         ack_never = 1'b0;

  // Per-transaction observations
  int          lat, nreq, nlog;
  logic        rerr, rbusy, rready;
  logic [31:0] rdat;
  logic [31:0] la [8];
  logic [7:0]  ld [8];
  int          lk [8];

  lsu_byte_master #(.TIMEOUT_CYC(16), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .busy(busy), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  assign bus_ack   = bus_req && !ack_never && (wcnt == ack_wait);
  assign bus_rdata = mem[bus_addr[7:0]];

  // Wait-state counter and byte memory
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= 0;
      for (int i = 0; i < 256; i++) mem[i] <= 8'h0;
    end else begin
      if (bus_req && !bus_ack) wcnt <= wcnt + 1;
      else                     wcnt <= 0;
      if (bus_req && bus_ack && bus_we) mem[bus_addr[7:0]] <= bus_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request; cycle k after the accept edge is sampled at negedge k
  task automatic run(input logic we, input logic [2:0] ctrl,
                     input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_ctrl = ctrl;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    lat = -1; nreq = 0; nlog = 0; rerr = 1'b0; rdat = 32'h0;
    rbusy = 1'b0; rready = 1'b1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (bus_req) nreq++;
      if (bus_req && bus_ack && nlog < 8) begin
        la[nlog] = bus_addr; ld[nlog] = bus_wdata; lk[nlog] = k; nlog++;
      end
      if (resp_valid) begin
        lat = k; rerr = resp_err; rdat = resp_rdata;
        rbusy = busy; rready = req_ready;
      end
    end
    if (lat < 0) check("resp_seen", 32'd0, 32'd1);
  endtask

  logic [31:0] sw_a [4] = '{32'h40, 32'h41, 32'h42, 32'h43};
  logic [7:0]  sw_d [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
  logic        seen;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctl", {26'h0, req_ready, busy, bus_req, resp_valid, resp_err, bus_we},
          32'b100000);
    check("rst_addr", bus_addr, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_wdata", {24'h0, bus_wdata}, 32'h0);
    rst_n = 1'b1;

    // sw 0x12345678 @0x40, zero-wait
    run(1'b1, 3'b010, 32'h40, 32'h12345678);
    check("sw_lat", lat, 5);
    check("sw_err", {31'h0, rerr}, 0);
    check("sw_rdata", rdat, 0);
    check("sw_nbytes", nlog, 4);
    check("sw_nreq", nreq, 4);
    for (int i = 0; i < 4; i++) begin
      check("sw_addr", la[i], sw_a[i]);
      check("sw_data", {24'h0, ld[i]}, {24'h0, sw_d[i]});
      check("sw_cyc", lk[i], i + 1);
    end
    check("sw_resp_busy", {30'h0, rbusy, rready}, 32'b10);

    // sb 0x80 @0x40 lands on byte +3 only
    run(1'b1, 3'b000, 32'h40, 32'hAAAA_AA80);
    check("sb_lat", lat, 2);
    check("sb_addr", la[0], 32'h43);
    check("sb_data", {24'h0, ld[0]}, 32'h80);

    // lb / lbu of 0x80
    run(1'b0, 3'b000, 32'h40, 32'h0);
    check("lb_lat", lat, 2);
    check("lb_rdata", rdat, 32'hFFFF_FF80);
    check("lb_nbytes", nlog, 1);
    check("lb_addr", la[0], 32'h43);
    run(1'b0, 3'b100, 32'h40, 32'h0);
    check("lbu_rdata", rdat, 32'h0000_0080);

    // sh 0x9ABC @0x44, then lh zero-wait and lhu with 3 wait states
    run(1'b1, 3'b001, 32'h44, 32'h1111_9ABC);
    check("sh_addr0", la[0], 32'h46);
    check("sh_data0", {24'h0, ld[0]}, 32'h9A);
    check("sh_data1", {24'h0, ld[1]}, 32'hBC);
    run(1'b0, 3'b001, 32'h44, 32'h0);
    check("lh_lat", lat, 3);
    check("lh_rdata", rdat, 32'hFFFF_9ABC);
    ack_wait = 3;
    run(1'b0, 3'b101, 32'h44, 32'h0);
    check("lhu_lat", lat, 9);
    check("lhu_rdata", rdat, 32'h0000_9ABC);
    check("lhu_nreq", nreq, 8);
    ack_wait = 0;

    // Decode errors: no bus activity, err at T+1
    run(1'b0, 3'b010, 32'h42, 32'h0);
    check("mis_lat", lat, 1);
    check("mis_err_nreq", {rerr, 31'(nreq)}, 32'h8000_0000);
    run(1'b1, 3'b010, 32'h3000, 32'h5555_5555);
    check("unm_err_nreq", {rerr, 31'(nreq)}, 32'h8000_0000);
    check("unm_lat", lat, 1);
    run(1'b1, 3'b101, 32'h44, 32'h0);
    check("stu_err_nreq", {rerr, 31'(nreq)}, 32'h8000_0000);
    run(1'b0, 3'b011, 32'h40, 32'h0);
    check("ctl_err_nreq", {rerr, 31'(nreq)}, 32'h8000_0000);
    check("ctl_rdata", rdat, 0);

    // Timeout: no ack ever
    ack_never = 1'b1;
    run(1'b0, 3'b010, 32'h1000, 32'h0);
    check("to_nreq", nreq, 16);
    check("to_lat", lat, 17);
    check("to_err", {31'h0, rerr}, 1);
    check("to_rdata", rdat, 0);
    @(negedge clk);
    check("to_ready_after", {31'h0, req_ready}, 1);
    ack_never = 1'b0;

    // Reset after two acks of a word load
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_ctrl = 3'b010; req_addr = 32'h40;
    @(posedge clk);
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_req_before", {31'h0, bus_req}, 1);
    rst_n = 1'b0;
    #1;
    check("mid_async", {29'h0, bus_req, busy, resp_valid}, 32'b000);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    check("mid_no_resp", {31'h0, seen}, 0);

    // Normal operation afterwards
    run(1'b1, 3'b010, 32'h2000, 32'hCAFE_F00D);
    check("post_sw_lat", lat, 5);
    run(1'b0, 3'b010, 32'h2000, 32'h0);
    check("post_lw_lat", lat, 5);
    check("post_lw_rdata", rdat, 32'hCAFE_F00D);
    check("post_lw_err", {31'h0, rerr}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_byte_master.md
Name: lsu_byte_master

Overview:
Load/store initiator for the data-memory/IO map. It sits in the MEM stage and accepts one word/half/byte request from the pipeline. It serialises the request into big-endian byte transfers on a byte-wide req/ack bus that the data memory and IO registers answer. It then returns sign- or zero-extended load data, or an error, and stalls the pipeline while busy.

Parameters:
TIMEOUT_CYC, 16, max cycles bus_req may wait for bus_ack on one byte before aborting
ADDR_W, 32, request and bus address width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  pipeline request present
req_ready  out  1  block idle, can accept
req_we  in  1  1=store, 0=load
req_ctrl  in  3  size/sign: 000 sb/lb, 001 sh/lh, 010 sw/lw, 100 lbu, 101 lhu
req_addr  in  ADDR_W  word-slot address
req_wdata  in  32  store data
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  valid with resp_valid
resp_rdata  out  32  extended load data (0 for stores/errors)
busy  out  1  pipeline stall, high from accept through resp cycle
bus_req  out  1  byte transfer request
bus_we  out  1  byte write
bus_addr  out  ADDR_W  byte address
bus_wdata  out  8  byte write data
bus_rdata  in  8  byte read data, valid when bus_ack
bus_ack  in  1  responder completes current byte this cycle

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0 except req_ready=1. Reset mid-transfer drops bus_req immediately and discards the transaction with no resp.
- Accept on req_valid && req_ready (cycle T). Latch addr, wdata, we, ctrl.
- Decode at accept. Error if any of the following:
  - req_addr[1:0]!=00 (misaligned; all sizes address a word slot).
  - req_addr[13:12]==11 (unmapped).
  - req_ctrl is 011/110/111.
  - req_we with ctrl 100/101.
- On a decode error: go to RESP with resp_err=1 at T+1, with no bus activity.
- Byte count n: 1 (x00), 2 (x01), 4 (010). Bytes are issued at addr+(4-n) … addr+3, ascending, MSB first. Store byte k takes wdata[8n-1-8k -: 8]. Examples: sw puts [31:24] at +0; sh puts [15:8] at +2 and [7:0] at +3; sb puts [7:0] at +3.
- FSM states: IDLE → XFER → RESP → IDLE.
  - XFER: bus_req held high. bus_addr/bus_we/bus_wdata are stable until ack.
  - On bus_ack: shift bus_rdata into the 32-bit accumulator and advance the byte counter. The next byte is presented in the next cycle; bus_req stays high, with no gap.
  - After the last ack: RESP.
- Zero-wait responder (ack in the same cycle as req): bus_req T+1..T+n, resp_valid at T+n+1. Word = T+5, byte = T+2.
- Wait counter resets on each ack. If it reaches TIMEOUT_CYC without ack: deassert bus_req, RESP with resp_err=1. Bytes already written stay written; there is no rollback.
- RESP: resp_valid=1 for exactly one cycle. There is no backpressure. req_ready=0 during RESP and rises in the following IDLE cycle. busy = !IDLE.
- Load extension: 000 sign-extends from bit 7; 001 from bit 15; 100/101 zero-extend; 010 passes the full word. Stores return resp_rdata=0.
- An ack seen in IDLE/RESP is ignored. req_valid while busy is ignored, not queued.

Decomposition:
- lsu_pkg holds:
  - dmctrl_e enum (LB=000, LH=001, LW=010, LBU=100, LHU=101).
  - Region constants on addr[13:12]: MEM=00, LED=01, SW=10, UNMAPPED=11.
  - lsu_state_e.
  - Byte-count function.
- One combinational sub-module, lsu_load_extend (ctrl + 32-bit accumulator → resp_rdata). The FSM, counters and accumulator stay in lsu_byte_master.

Test Plan:
- sw 0x12345678 @0x40, zero-wait ack → bus writes 0x12@0x40, 0x34@0x41, 0x56@0x42, 0x78@0x43 on T+1..T+4; resp_valid at T+5, err=0, rdata=0.
- mem[0x43]=0x80: lb @0x40 → resp_rdata 0xFFFFFF80 at T+2; lbu → 0x00000080; only bus_addr 0x43 is issued.
- mem[0x46]=0x9A, mem[0x47]=0xBC: lh @0x44 → 0xFFFF9ABC; lhu → 0x00009ABC. Also insert 3 wait cycles before each ack → resp at T+9.
- lw @0x42 and sw @0x3000 → resp_err=1 at T+1, bus_req never asserted. Same result for sh with ctrl 101 (store-unsigned illegal).
- lw @0x1000, responder never acks → bus_req high for exactly 16 cycles, then resp_err=1, rdata=0; req_ready=1 the cycle after.
- Mid-word, after 2 acks, pulse rst_n low → bus_req and busy fall asynchronously with no resp_valid. A new lw @0x2000 afterwards completes normally.
